// File: rtl/river_line_fetch.sv
// River line fetcher: per-frame scroll position, per-line offset fetch from the
// river-offset ROM during horizontal blank, registered stream edges and in_stream flag.
module river_line_fetch #(
  parameter int BASE            = 220,
  parameter int WIDTH           = 63,
  parameter int PREFETCH_X      = 700,
  parameter int FRAME_Y         = 480,
  parameter int V_TOTAL         = 525,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [7:0] rom_addr,
  input  logic [5:0] rom_data,
  output logic [9:0] stream_left,
  output logic [9:0] stream_right,
  output logic       in_stream,
  output logic [7:0] scroll_pos,
  output logic       frame_tick
);

  localparam int             CW         = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0]  LAST_FRAME = CW'(FRAMES_PER_STEP - 1);
  localparam logic [9:0]     BASE_X     = 10'(BASE);
  localparam logic [9:0]     WIDTH_X    = 10'(WIDTH);
  localparam logic [9:0]     LAST_ROW   = 10'(V_TOTAL - 1);

  logic          frame_match;
  logic          line_match;
  logic          frame_match_q;
  logic          line_match_q;
  logic          frame_fire;
  logic          line_fire;
  logic [7:0]    next_row;
  logic [7:0]    fetch_addr;
  logic [9:0]    fetched_left;
  logic [CW-1:0] frame_cnt;
  logic [1:0]    fetch_valid;

  // Pixel coordinates may hold for several clk cycles; events fire only on the
  // first cycle of a match.
  always_comb begin
    // NOTE: every signal is assigned on every path so no latch can be inferred.
    frame_match  = (pixel_x == 10'd0) && (pixel_y == 10'(FRAME_Y));
    line_match   = (pixel_x == 10'(PREFETCH_X));
    frame_fire   = frame_match && !frame_match_q;
    line_fire    = line_match && !line_match_q;
    next_row     = (pixel_y == LAST_ROW) ? 8'd0 : pixel_y[7:0] + 8'd1;
    fetch_addr   = next_row + scroll_pos;
    fetched_left = BASE_X + {4'b0000, rom_data};
  end

  // Frame event and scroll position; subtracting makes the river flow downward.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      frame_match_q <= 1'b0;
      frame_tick    <= 1'b0;
      frame_cnt     <= '0;
      scroll_pos    <= 8'd0;
    end else begin
      frame_match_q <= frame_match;
      frame_tick    <= frame_fire;
      if (frame_tick && run) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt  <= '0;
          scroll_pos <= scroll_pos - {5'b00000, speed};
        end else begin
          frame_cnt  <= frame_cnt + CW'(1);
        end
      end
    end
  end

  // Two-stage fetch: address out at T+1, ROM data captured at T+2. Edges hold
  // between fetches so a line never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_match_q <= 1'b0;
      fetch_valid  <= 2'b00;
      rom_addr     <= 8'd0;
      stream_left  <= BASE_X;
      stream_right <= BASE_X + WIDTH_X;
    end else begin
      line_match_q <= line_match;
      fetch_valid  <= {fetch_valid[0], line_fire};
      if (line_fire) begin
        rom_addr <= fetch_addr;
      end
      if (fetch_valid[1]) begin
        stream_left  <= fetched_left;
        stream_right <= fetched_left + WIDTH_X;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_stream <= 1'b0;
    end else begin
      in_stream <= video_on && (pixel_x >= stream_left) && (pixel_x <= stream_right);
    end
  end

endmodule

// File: tb/tb_river_line_fetch.sv
// Self-checking bench for river_line_fetch: directed steps plus randomized
// fetches and frames compared against a behavioural scroll/edge model.
module tb_river_line_fetch;

  localparam int BASE       = 220;
  localparam int WIDTH      = 63;
  localparam int PREFETCH_X = 700;
  localparam int FRAME_Y    = 480;
  localparam int V_TOTAL    = 525;
  localparam int FPS        = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       run;
  logic [2:0] speed;
  logic [7:0] rom_addr;
  logic [5:0] rom_data;
  logic [9:0] stream_left;
  logic [9:0] stream_right;
  logic       in_stream;
  logic [7:0] scroll_pos;
  logic       frame_tick;

  logic [5:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_scroll = 0;
  int m_cnt    = 0;
  int m_left   = BASE;
  int m_right  = BASE + WIDTH;

  river_line_fetch #(
    .BASE(BASE), .WIDTH(WIDTH), .PREFETCH_X(PREFETCH_X), .FRAME_Y(FRAME_Y),
    .V_TOTAL(V_TOTAL), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .run(run), .speed(speed), .rom_addr(rom_addr),
    .rom_data(rom_data), .stream_left(stream_left), .stream_right(stream_right),
    .in_stream(in_stream), .scroll_pos(scroll_pos), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Offset ROM: registered read, one cycle latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int y, input int s);
    int row;
    row = (y == V_TOTAL - 1) ? 0 : y + 1;
    return (row + s) % 256;
  endfunction

  task automatic model_reset();
    m_scroll = 0;
    m_cnt    = 0;
    m_left   = BASE;
    m_right  = BASE + WIDTH;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rom_addr"},     rom_addr,     0);
    check({tag, ".scroll_pos"},   scroll_pos,   0);
    check({tag, ".stream_left"},  stream_left,  BASE);
    check({tag, ".stream_right"}, stream_right, BASE + WIDTH);
    check({tag, ".in_stream"},    in_stream,    0);
    check({tag, ".frame_tick"},   frame_tick,   0);
  endtask

  // One frame event, match held three clocks; checks a single-cycle pulse and
  // the resulting scroll position.
  task automatic do_frame(input string tag);
    pixel_x = 10'd0;
    pixel_y = 10'(FRAME_Y);
    tick(1);
    check({tag, ".tick_hi"}, frame_tick, 1);
    check({tag, ".scroll_pre"}, scroll_pos, m_scroll);
    tick(1);
    check({tag, ".tick_lo1"}, frame_tick, 0);
    tick(1);
    check({tag, ".tick_lo2"}, frame_tick, 0);
    pixel_x = 10'd1;
    tick(1);
    check({tag, ".tick_lo3"}, frame_tick, 0);
    if (run) begin
      if (m_cnt == FPS - 1) begin
        m_cnt    = 0;
        m_scroll = (m_scroll - int'(speed) + 256) % 256;
      end else begin
        m_cnt++;
      end
    end
    check({tag, ".scroll"}, scroll_pos, m_scroll);
  endtask

  task automatic do_fetch(input string tag, input int y);
    int a;
    pixel_y = 10'(y);
    pixel_x = 10'(PREFETCH_X - 1);
    tick(1);
    pixel_x = 10'(PREFETCH_X);
    tick(1);
    a = exp_addr(y, m_scroll);
    check({tag, ".rom_addr"}, rom_addr, a);
    pixel_x = 10'(PREFETCH_X + 1);
    tick(2);
    m_left  = BASE + int'(rom[a]);
    m_right = m_left + WIDTH;
    check({tag, ".left"},  stream_left,  m_left);
    check({tag, ".right"}, stream_right, m_right);
  endtask

  initial begin
    int xs[4];
    int a;
    for (int i = 0; i < 256; i++) rom[i] = 6'($urandom_range(0, 63));

    // Reset with pixel inputs moving
    reset    = 1'b1;
    video_on = 1'b1;
    run      = 1'b0;
    speed    = 3'd0;
    pixel_y  = 10'd9;
    pixel_x  = 10'd250;
    tick(1);
    pixel_x  = 10'd251;
    tick(1);
    check_reset_state("reset");
    reset    = 1'b0;
    video_on = 1'b0;
    model_reset();

    // Directed fetch: row 9 -> address 10, ROM value 17; match held two clocks
    rom[10]  = 6'd17;
    pixel_y  = 10'd9;
    pixel_x  = 10'(PREFETCH_X - 1);
    tick(1);
    pixel_x  = 10'(PREFETCH_X);
    tick(1);
    check("fetch.rom_addr_t1", rom_addr, 10);
    check("fetch.left_hold_t1", stream_left, BASE);
    tick(1);
    check("fetch.left_hold_t2", stream_left, BASE);
    rom[10]  = 6'd40;  // a duplicate fetch would now pick this up
    pixel_x  = 10'(PREFETCH_X + 1);
    tick(1);
    check("fetch.left_t3",  stream_left,  237);
    check("fetch.right_t3", stream_right, 300);
    tick(2);
    check("fetch.left_once",  stream_left,  237);
    check("fetch.right_once", stream_right, 300);
    m_left  = 237;
    m_right = 300;

    // Inclusive edge comparisons, one cycle latency
    video_on = 1'b1;
    xs = '{236, 237, 300, 301};
    foreach (xs[i]) begin
      pixel_x = 10'(xs[i]);
      tick(1);
      check($sformatf("edge.x%0d", xs[i]), in_stream, (xs[i] >= m_left && xs[i] <= m_right) ? 1 : 0);
    end
    video_on = 1'b0;
    pixel_x  = 10'd250;
    tick(1);
    check("edge.video_off", in_stream, 0);
    for (int i = 0; i < 20; i++) begin
      int x;
      logic v;
      x = $urandom_range(1, PREFETCH_X - 1);
      if (i % 3 == 0) x = m_left - 1 + (i % 4);
      v = 1'($urandom_range(0, 1));
      pixel_x  = 10'(x);
      video_on = v;
      tick(1);
      check($sformatf("edge.rand%0d", i), in_stream, (v && x >= m_left && x <= m_right) ? 1 : 0);
    end
    video_on = 1'b0;

    // Directed scroll: speed 3, step every two frames, then frozen
    run   = 1'b1;
    speed = 3'd3;
    for (int f = 0; f < 4; f++) do_frame($sformatf("scroll.run%0d", f));
    check("scroll.after_run", scroll_pos, 250);
    run = 1'b0;
    for (int f = 0; f < 3; f++) do_frame($sformatf("scroll.hold%0d", f));
    check("scroll.after_hold", scroll_pos, 250);

    // Row wrap at the last line, then address wrap modulo 256
    do_fetch("wrap.last_row", V_TOTAL - 1);
    check("wrap.last_row_addr", rom_addr, 250);
    do_fetch("wrap.row9", 9);
    check("wrap.row9_addr", rom_addr, 4);

    // Randomized frames and fetches
    for (int f = 0; f < 6; f++) begin
      run   = 1'($urandom_range(0, 1));
      speed = 3'($urandom_range(0, 7));
      do_frame($sformatf("rand.frame%0d", f));
    end
    for (int i = 0; i < 8; i++) begin
      do_fetch($sformatf("rand.fetch%0d", i), $urandom_range(0, V_TOTAL - 1));
    end

    // Reset during T+1 of a fetch: edges return, no capture afterwards
    a = exp_addr(100, m_scroll);
    rom[a]  = 6'd33;
    pixel_y = 10'd100;
    pixel_x = 10'(PREFETCH_X - 1);
    tick(1);
    pixel_x = 10'(PREFETCH_X);
    tick(1);
    check("midreset.rom_addr_t1", rom_addr, a);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    check_reset_state("midreset");
    pixel_x = 10'(PREFETCH_X + 1);
    tick(2);
    check("midreset.no_capture_left",  stream_left,  BASE);
    check("midreset.no_capture_right", stream_right, BASE + WIDTH);

    // Frame counter restarts from zero after reset
    run   = 1'b1;
    speed = 3'd5;
    do_frame("post_reset.f0");
    check("post_reset.f0_scroll", scroll_pos, 0);
    do_frame("post_reset.f1");
    check("post_reset.f1_scroll", scroll_pos, 251);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
